nn_input_sequencer: RTL and testbench

//  Upstream feeder for the tanh neural network stage. Accepts a stream of signed 8-bit samples,

---
 rtl/nn_pkg.sv | 14 +
 rtl/nn_pingpong_buf.sv | 91 +++++++++
 rtl/nn_input_sequencer.sv | 135 +++++++++++++
 tb/tb_nn_input_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared sample type, width and sequencer state encoding for the nn input feeder.
package nn_pkg;
    localparam int DATA_W = 8;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic [2:0] {
        IDLE,
        NRST,
        FILL,
        RUN,
        DONE
    } seq_state_t;
endpackage

// File: rtl/nn_pingpong_buf.sv
// Two-bank vector buffer: write side packs samples, read side serves the network.
// Read data registered (1 cycle); wr_ready drops while the write bank is still full.
module nn_pingpong_buf #(
    parameter int DATA_W   = 8,
    parameter int N_INPUTS = 2,
    parameter int AW       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              early_last,
    input  logic              rd_trig,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_full,
    output logic              rd_last,
    output logic              other_full,
    input  logic              release_bank
);
    localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    logic [DATA_W-1:0] mem [2][N_INPUTS];
    logic [1:0]        full;
    logic [1:0]        last;
    logic [1:0]        full_nxt;
    logic              wbank;
    logic              rbank;
    logic              en;
    logic [IW-1:0]     widx;
    logic              accept;
    logic              final_elem;

    assign wr_ready   = en & ~full[wbank];
    assign accept     = wr_valid & wr_ready;
    assign final_elem = (widx == IW'(N_INPUTS - 1));
    assign early_last = accept & wr_last & ~final_elem;
    assign rd_full    = full[rbank];
    assign rd_last    = last[rbank];
    assign other_full = full[~rbank];

    always_comb begin
        full_nxt = full;
        if (release_bank)
            full_nxt[rbank] = 1'b0;
        if (accept && final_elem)
            full_nxt[wbank] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full    <= '0;
            last    <= '0;
            wbank   <= 1'b0;
            rbank   <= 1'b0;
            widx    <= '0;
            en      <= 1'b0;
            rd_data <= '0;
        end else begin
            en   <= 1'b1;
            full <= full_nxt;
            if (release_bank)
                rbank <= ~rbank;
            // Move the write pointer as soon as its bank is full and the other is free,
            // so a bank released this cycle is writable on the next one.
            if (full_nxt[wbank] && !full_nxt[~wbank])
                wbank <= ~wbank;
            if (accept) begin
                if (final_elem) begin
                    widx        <= '0;
                    last[wbank] <= wr_last;
                end else begin
                    widx <= widx + 1'b1;
                end
            end
            if (rd_trig) begin
                rd_data <= '0;
                for (int i = 0; i < N_INPUTS; i++)
                    if (rd_addr == AW'(i))
                        rd_data <= mem[rbank][i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wbank][widx] <= wr_data;
    end
endmodule

// File: rtl/nn_input_sequencer.sv
// Packs samples into vectors and drives the tanh network through reset/fill/run per vector.
// Vector start 2 cycles after its last sample; in_ready low while both banks are full.
module nn_input_sequencer #(
    parameter int DATA_W   = nn_pkg::DATA_W,
    parameter int N_INPUTS = 2,
    parameter int AW       = 1,
    parameter int TIMEOUT  = 1024,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              net_rst,
    output logic              net_fill,
    output logic              net_req,
    input  logic              net_rd_trig,
    input  logic [AW-1:0]     net_rd_addr,
    output logic [DATA_W-1:0] net_rd_data,
    input  logic              net_ack_fill,
    input  logic              net_ack_network,
    output logic              busy,
    output logic              vec_done,
    output logic              seq_done,
    output logic [CNT_W-1:0]  vec_count,
    output logic [1:0]        err
);
    import nn_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_t    state;
    logic [TW-1:0] timer;
    logic          timeout_hit;
    logic          fill_to;
    logic          run_to;
    logic          release_bank;
    logic          rd_full;
    logic          rd_last;
    logic          other_full;
    logic          early_last;

    nn_pingpong_buf #(
        .DATA_W  (DATA_W),
        .N_INPUTS(N_INPUTS),
        .AW      (AW)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .wr_valid    (in_valid),
        .wr_ready    (in_ready),
        .wr_data     (in_data),
        .wr_last     (in_last),
        .early_last  (early_last),
        .rd_trig     (net_rd_trig),
        .rd_addr     (net_rd_addr),
        .rd_data     (net_rd_data),
        .rd_full     (rd_full),
        .rd_last     (rd_last),
        .other_full  (other_full),
        .release_bank(release_bank)
    );

    assign timeout_hit  = (timer == TW'(TIMEOUT - 1));
    assign fill_to      = (state == FILL) && !net_ack_fill && timeout_hit;
    assign run_to       = (state == RUN) && !net_ack_network && timeout_hit;
    assign release_bank = (state == DONE) || fill_to || run_to;
    assign busy         = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            timer     <= '0;
            net_rst   <= 1'b1;
            net_fill  <= 1'b0;
            net_req   <= 1'b0;
            vec_done  <= 1'b0;
            seq_done  <= 1'b0;
            vec_count <= '0;
            err       <= '0;
        end else begin
            vec_done <= 1'b0;
            seq_done <= 1'b0;
            timer    <= timer + 1'b1;
            if (early_last)
                err[1] <= 1'b1;
            if (fill_to || run_to) begin
                // Stuck network: drop this vector and go straight on to the next if it is ready.
                err[0]   <= 1'b1;
                net_fill <= 1'b0;
                net_req  <= 1'b0;
                net_rst  <= 1'b1;
                timer    <= '0;
                state    <= other_full ? NRST : IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rd_full)
                            state <= NRST;
                    end
                    NRST: begin
                        state    <= FILL;
                        net_rst  <= 1'b0;
                        net_fill <= 1'b1;
                        timer    <= '0;
                    end
                    FILL: begin
                        if (net_ack_fill) begin
                            state    <= RUN;
                            net_fill <= 1'b0;
                            net_req  <= 1'b1;
                            timer    <= '0;
                        end
                    end
                    RUN: begin
                        if (net_ack_network) begin
                            state     <= DONE;
                            net_req   <= 1'b0;
                            vec_done  <= 1'b1;
                            seq_done  <= rd_last;
                            vec_count <= vec_count + 1'b1;
                        end
                    end
                    DONE: begin
                        state   <= IDLE;
                        net_rst <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nn_input_sequencer.sv
// Directed bench: main instance (N_INPUTS=2) plus a single-element, short-timeout instance.
module tb_nn_input_sequencer;
    import nn_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid, in_ready, in_last;
    logic [7:0]  in_data, net_rd_data;
    logic        net_rst, net_fill, net_req, net_rd_trig, net_ack_fill, net_ack_network;
    logic [0:0]  net_rd_addr;
    logic        busy, vec_done, seq_done;
    logic [15:0] vec_count;
    logic [1:0]  err;

    logic        in_valid_b, in_ready_b, in_last_b;
    logic [7:0]  in_data_b, net_rd_data_b;
    logic        net_rst_b, net_fill_b, net_req_b, net_rd_trig_b, net_ack_fill_b, net_ack_network_b;
    logic [0:0]  net_rd_addr_b;
    logic        busy_b, vec_done_b, seq_done_b;
    logic [15:0] vec_count_b;
    logic [1:0]  err_b;

    int          n_chk = 0;
    int          n_fail = 0;
    int          acc;
    logic [7:0]  rd0 [3];
    logic [7:0]  rd1 [3];
    logic        sdv [3];
    logic [7:0]  d0, d1;
    logic        sd;
    sample_t     samp;

    nn_input_sequencer #(.DATA_W(8), .N_INPUTS(2), .AW(1), .TIMEOUT(1024), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .net_rst(net_rst), .net_fill(net_fill), .net_req(net_req),
        .net_rd_trig(net_rd_trig), .net_rd_addr(net_rd_addr), .net_rd_data(net_rd_data),
        .net_ack_fill(net_ack_fill), .net_ack_network(net_ack_network), .busy(busy),
        .vec_done(vec_done), .seq_done(seq_done), .vec_count(vec_count), .err(err)
    );

    nn_input_sequencer #(.DATA_W(8), .N_INPUTS(1), .AW(1), .TIMEOUT(16), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .in_last(in_last_b), .net_rst(net_rst_b), .net_fill(net_fill_b), .net_req(net_req_b),
        .net_rd_trig(net_rd_trig_b), .net_rd_addr(net_rd_addr_b), .net_rd_data(net_rd_data_b),
        .net_ack_fill(net_ack_fill_b), .net_ack_network(net_ack_network_b), .busy(busy_b),
        .vec_done(vec_done_b), .seq_done(seq_done_b), .vec_count(vec_count_b), .err(err_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 500) begin
            tick();
            n++;
        end
        check_eq("send_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] d);
        int n = 0;
        in_valid_b = 1'b1;
        in_data_b  = d;
        in_last_b  = 1'b1;
        while (!in_ready_b && n < 100) begin
            tick();
            n++;
        end
        check_eq("b_send_ready", in_ready_b, 1);
        tick();
        in_valid_b = 1'b0;
    endtask

    task automatic net_vector(input int run_wait, output logic [7:0] r0, output logic [7:0] r1,
                              output logic s);
        int n = 0;
        while (!net_fill && n < 300) begin
            tick();
            n++;
        end
        check_eq("fill_seen", net_fill, 1);
        net_rd_trig = 1'b1;
        net_rd_addr = 1'b0;
        tick();
        r0 = net_rd_data;
        net_rd_addr = 1'b1;
        tick();
        r1 = net_rd_data;
        net_rd_trig  = 1'b0;
        net_ack_fill = 1'b1;
        tick();
        check_eq("req_on", net_req, 1);
        repeat (run_wait) tick();
        net_ack_network = 1'b1;
        tick();
        check_eq("vec_done", vec_done, 1);
        s = seq_done;
        net_ack_fill    = 1'b0;
        net_ack_network = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 0; in_data = 0; in_last = 0;
        net_rd_trig = 0; net_rd_addr = 0; net_ack_fill = 0; net_ack_network = 0;
        in_valid_b = 0; in_data_b = 0; in_last_b = 0;
        net_rd_trig_b = 0; net_rd_addr_b = 0; net_ack_fill_b = 0; net_ack_network_b = 0;
        #2 rst = 1'b0;
        #1;
        check_eq("rst_net_rst", net_rst, 1);
        check_eq("rst_fill", net_fill, 0);
        check_eq("rst_req", net_req, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_rd_data", net_rd_data, 0);
        check_eq("rst_vec_count", vec_count, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Basic vector with full handshake and NRST timing
        send(8'h10, 1'b0);
        send(8'hF0, 1'b1);
        check_eq("t1_idle", busy, 0);
        tick();
        check_eq("t1_nrst_rst", net_rst, 1);
        check_eq("t1_nrst_busy", busy, 1);
        check_eq("t1_nrst_fill", net_fill, 0);
        tick();
        check_eq("t1_fill_rst", net_rst, 0);
        check_eq("t1_fill_on", net_fill, 1);
        net_rd_trig = 1'b1; net_rd_addr = 1'b0;
        tick();
        check_eq("t1_rd0", net_rd_data, 8'h10);
        net_rd_addr = 1'b1;
        tick();
        check_eq("t1_rd1", net_rd_data, 8'hF0);
        net_rd_trig = 1'b0; net_rd_addr = 1'b0;
        tick();
        check_eq("t1_rd_hold", net_rd_data, 8'hF0);
        check_eq("t1_fill_held", net_fill, 1);
        net_ack_fill = 1'b1;
        tick();
        check_eq("t1_fill_off", net_fill, 0);
        check_eq("t1_req_on", net_req, 1);
        tick();
        check_eq("t1_req_held", net_req, 1);
        net_ack_network = 1'b1;
        tick();
        check_eq("t1_vec_done", vec_done, 1);
        check_eq("t1_seq_done", seq_done, 1);
        check_eq("t1_vec_count", vec_count, 1);
        check_eq("t1_req_off", net_req, 0);
        check_eq("t1_done_rst", net_rst, 0);
        net_ack_fill = 1'b0; net_ack_network = 1'b0;
        tick();
        check_eq("t1_pulse_end", vec_done, 0);
        check_eq("t1_back_idle", busy, 0);
        check_eq("t1_idle_rst", net_rst, 1);

        // in_last on element 0: flagged, vector still processed, no sequence end
        fork
            begin
                send(8'h7F, 1'b1);
                send(8'h80, 1'b0);
            end
            net_vector(3, d0, d1, sd);
        join
        check_eq("t3_rd0", d0, 8'h7F);
        check_eq("t3_rd1", d1, 8'h80);
        check_eq("t3_seq_done", sd, 0);
        check_eq("t3_err", err, 2'b10);
        check_eq("t3_vec_count", vec_count, 2);

        // Reset while in RUN with a partial vector pending in the other bank
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h99, 1'b0);
        begin
            int n = 0;
            while (!net_fill && n < 100) begin
                tick();
                n++;
            end
        end
        check_eq("t5_fill", net_fill, 1);
        net_ack_fill = 1'b1;
        tick();
        check_eq("t5_run", net_req, 1);
        tick();
        rst = 1'b0;
        #1;
        check_eq("t5_async_req", net_req, 0);
        check_eq("t5_async_rst", net_rst, 1);
        check_eq("t5_async_busy", busy, 0);
        check_eq("t5_async_cnt", vec_count, 0);
        check_eq("t5_async_err", err, 0);
        check_eq("t5_async_rdy", in_ready, 0);
        check_eq("t5_async_rd", net_rd_data, 0);
        net_ack_fill = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        fork
            begin
                send(8'h33, 1'b0);
                send(8'h44, 1'b1);
            end
            net_vector(2, d0, d1, sd);
        join
        check_eq("t5_rd0", d0, 8'h33);
        check_eq("t5_rd1", d1, 8'h44);
        check_eq("t5_seq_done", sd, 1);
        check_eq("t5_vec_count", vec_count, 1);

        // Streaming six samples against a slow network
        do_reset();
        acc = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    samp = sample_t'(i + 1);
                    send(samp, (i == 5));
                    acc++;
                end
            end
            begin
                for (int v = 0; v < 3; v++)
                    net_vector(50, rd0[v], rd1[v], sdv[v]);
            end
            begin
                int n = 0;
                while (acc < 4 && n < 300) begin
                    tick();
                    n++;
                end
                repeat (5) tick();
                check_eq("t2_stall_rdy", in_ready, 0);
                check_eq("t2_stall_acc", acc, 4);
            end
        join
        for (int v = 0; v < 3; v++) begin
            check_eq($sformatf("t2_rd0_v%0d", v), rd0[v], 8'(2 * v + 1));
            check_eq($sformatf("t2_rd1_v%0d", v), rd1[v], 8'(2 * v + 2));
            check_eq($sformatf("t2_sd_v%0d", v), sdv[v], (v == 2) ? 1 : 0);
        end
        check_eq("t2_vec_count", vec_count, 3);
        check_eq("t2_err", err, 0);

        // Timeout in FILL on the single-element instance, then the next vector runs
        send_b(8'h55);
        send_b(8'h66);
        begin
            int n = 0;
            while (!net_fill_b && n < 100) begin
                tick();
                n++;
            end
        end
        check_eq("t4_fill", net_fill_b, 1);
        repeat (15) tick();
        check_eq("t4_pre_err", err_b, 0);
        check_eq("t4_pre_fill", net_fill_b, 1);
        tick();
        check_eq("t4_err", err_b, 2'b01);
        check_eq("t4_fill_off", net_fill_b, 0);
        check_eq("t4_nrst", net_rst_b, 1);
        check_eq("t4_no_done", vec_done_b, 0);
        check_eq("t4_cnt0", vec_count_b, 0);
        tick();
        check_eq("t4_refill", net_fill_b, 1);
        net_rd_trig_b = 1'b1; net_rd_addr_b = 1'b0;
        tick();
        check_eq("t4_rd0", net_rd_data_b, 8'h66);
        net_rd_addr_b = 1'b1;
        tick();
        check_eq("t4_rd_oob", net_rd_data_b, 8'h00);
        net_rd_trig_b = 1'b0;
        net_ack_fill_b = 1'b1;
        tick();
        net_ack_network_b = 1'b1;
        tick();
        check_eq("t4_vec_done", vec_done_b, 1);
        check_eq("t4_seq_done", seq_done_b, 1);
        check_eq("t4_cnt1", vec_count_b, 1);
        check_eq("t4_err_sticky", err_b, 2'b01);
        net_ack_fill_b = 1'b0; net_ack_network_b = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
